mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch requester (I) and the load/store requester (D) of the xgriscv core. Each requester issues one transaction at a time with a req/ack handshake. The arbiter selects an owner, registers the transaction onto the memory bus, waits for the memory response and returns a one-cycle ack to that owner. It sits between the pc register / store-pattern logic and the memory model, and is the source of fetch/memory stalls.

Parameters:
XLEN, 32, data width
ADDR_SIZE, 32, address width
FAIR, 1, 1 = round-robin on conflict; 0 = fixed D-over-I priority
TIMEOUT, 255, max cycles in WAIT before error completion; 0 disables the timer

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_SIZE  fetch address
i_ack  out  1  one-cycle completion pulse to I
i_rdata  out  XLEN  fetched word, valid while i_ack=1
i_err  out  1  timeout flag, valid while i_ack=1
d_req  in  1  load/store request, held until d_ack
d_we  in  1  1 = store
d_addr  in  ADDR_SIZE  data address
d_be  in  4  byte enables (store pattern), 4'b1111 for loads
d_wdata  in  XLEN  store data
d_ack  out  1  one-cycle completion pulse to D
d_rdata  out  XLEN  load data, valid while d_ack=1
d_err  out  1  timeout flag, valid while d_ack=1
m_req  out  1  memory request
m_we  out  1  memory write
m_addr  out  ADDR_SIZE  memory address
m_be  out  4  memory byte enables
m_wdata  out  XLEN  memory write data
m_gnt  in  1  memory accepts the request this cycle
m_rvalid  in  1  memory completes the accepted request (reads and writes)
m_rdata  in  XLEN  memory read data, valid with m_rvalid

Behaviour:
- Reset: asynchronous, active-high. State IDLE. All outputs 0. Owner/RR pointer set to I-last, so D wins the first conflict. Timer 0.
- States: IDLE, REQ, WAIT, DONE. All bus and ack outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: that requester becomes owner.
  - Both requesting, FAIR=0: D wins.
  - Both requesting, FAIR=1: the requester not served last wins.
  - On selection: latch owner, m_addr/m_we/m_be/m_wdata, set m_req=1, go to REQ. I transactions drive m_we=0 and m_be=4'b1111.
- REQ: hold m_req and all bus fields stable. When m_gnt=1, clear m_req next cycle, clear timer, go to WAIT.
- WAIT:
  - m_rvalid=1: capture m_rdata into the owner's rdata, err=0, go to DONE.
  - Otherwise, if TIMEOUT!=0: timer increments; at timer==TIMEOUT-1 with no m_rvalid, go to DONE with err=1 and rdata=0.
- DONE: owner's ack=1 for exactly this cycle; next state IDLE; RR pointer updated to this owner. Requests sampled during DONE are ignored.
- Minimum latency: request in cycle 0 → m_req cycle 1 → m_gnt cycle 1 → m_rvalid cycle 2 → ack cycle 3. Back-to-back transactions from one requester: at best 4 cycles each.
- One outstanding transaction only.
  - m_rvalid outside WAIT is ignored.
  - m_gnt outside REQ is ignored.
  - A response arriving after a timeout is discarded.
- Ack, rdata and err are zero for the non-owner. rdata holds its value after ack deasserts; err clears.
- A requester dropping req before its ack does not abort the transaction; the ack is still issued.
- Reset mid-transaction: return to IDLE immediately and drop m_req. Any later memory response is ignored.

Decomposition:
- xgriscv_defines.v: ARB_IDLE/ARB_REQ/ARB_WAIT/ARB_DONE state encodings (2 bits), OWNER_I/OWNER_D encodings, BE_WORD=4'b1111.
- Sub-module arb_pick2: combinational 2-way picker. Inputs: i_req, d_req, last_owner, fair. Outputs: grant_i, grant_d (one-hot or zero).

Test Plan:
- I only, addr 0x80000000, memory gnt at once, rvalid 1 cycle later with 0x00000013 → i_ack in cycle 3, i_rdata=0x00000013, m_we=0, m_be=4'hF.
- D store addr 0x80001002, be 4'b1100, wdata 0xABCD0000, m_gnt delayed 3 cycles → m_req and bus fields stable for 4 cycles, then d_ack and d_err=0.
- I and D asserted together, FAIR=1, 3 rounds → grants D,I,D,I,D,I. Same stimulus with FAIR=0 → D every round while d_req is held.
- TIMEOUT=8, memory never asserts rvalid → d_ack 8 cycles after entering WAIT, d_err=1, d_rdata=0. A late m_rvalid does not produce a second ack.
- reset pulse during WAIT → all outputs 0 asynchronously. A subsequent m_rvalid produces no ack. Next i_req served normally.
- Back-to-back fetches 0x80000000, 0x80000004 with zero-wait memory → acks 4 cycles apart, data in order.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Width of the WAIT-state timer; it only ever counts up to timeout-1.
  function automatic int timer_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (I/D) and memory-side signals of the arbiter, bundled.
interface mem_port_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
);

  logic                 i_req;
  logic [ADDR_SIZE-1:0] i_addr;
  logic                 i_ack;
  logic [XLEN-1:0]      i_rdata;
  logic                 i_err;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_SIZE-1:0] d_addr;
  logic [3:0]           d_be;
  logic [XLEN-1:0]      d_wdata;
  logic                 d_ack;
  logic [XLEN-1:0]      d_rdata;
  logic                 d_err;

  logic                 m_req;
  logic                 m_we;
  logic [ADDR_SIZE-1:0] m_addr;
  logic [3:0]           m_be;
  logic [XLEN-1:0]      m_wdata;
  logic                 m_gnt;
  logic                 m_rvalid;
  logic [XLEN-1:0]      m_rdata;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
           m_gnt, m_rvalid, m_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           m_req, m_we, m_addr, m_be, m_wdata
  );

  // Requesters plus memory model view
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
           m_gnt, m_rvalid, m_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           m_req, m_we, m_addr, m_be, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick2.sv
// Combinational two-way picker between fetch (I) and load/store (D).
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  input  logic   fair,
  output logic   grant_i,
  output logic   grant_d
);

  // On conflict D wins under fixed priority, or under round-robin when I went last
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
      if (!fair || last_owner == OWNER_I) grant_d = 1'b1;
      else                                grant_i = 1'b1;
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store,
// one outstanding transaction at a time, with an optional response timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int FAIR      = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  localparam int              TW         = timer_width(TIMEOUT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t           state;
  owner_t               owner;
  owner_t               last_owner;
  logic [TW-1:0]        timer;
  logic                 grant_i;
  logic                 grant_d;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [XLEN-1:0]      rsp_data;
  logic                 timed_out;

  arb_pick2 u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_owner (last_owner),
    .fair       (FAIR != 0),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // Selected address, response data (zero on timeout) and the timeout condition
  always_comb begin
    sel_addr  = grant_d ? bus.d_addr : bus.i_addr;
    rsp_data  = bus.m_rvalid ? bus.m_rdata : '0;
    timed_out = (TIMEOUT != 0) && !bus.m_rvalid && (timer == TIMER_LAST);
  end

  // Transaction FSM with registered bus, ack, data and error outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      owner       <= OWNER_I;
      last_owner  <= OWNER_I;
      timer       <= '0;
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_be    <= '0;
      bus.m_wdata <= '0;
      bus.i_ack   <= 1'b0;
      bus.i_rdata <= '0;
      bus.i_err   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.d_rdata <= '0;
      bus.d_err   <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.i_err <= 1'b0;
      bus.d_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_i || grant_d) begin
            owner       <= grant_d ? OWNER_D : OWNER_I;
            bus.m_req   <= 1'b1;
            bus.m_we    <= grant_d && bus.d_we;
            bus.m_addr  <= sel_addr;
            bus.m_be    <= grant_d ? bus.d_be : BE_WORD;
            bus.m_wdata <= grant_d ? bus.d_wdata : '0;
            state       <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus.m_gnt) begin
            bus.m_req <= 1'b0;
            timer     <= '0;
            state     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.m_rvalid || timed_out) begin
            // Completion clears the other requester's data so only the owner shows a value
            if (owner == OWNER_D) begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= rsp_data;
              bus.d_err   <= timed_out;
              bus.i_rdata <= '0;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_rdata <= rsp_data;
              bus.i_err   <= timed_out;
              bus.d_rdata <= '0;
            end
            state <= ARB_DONE;
          end else if (TIMEOUT != 0) begin
            timer <= timer + 1'b1;
          end
        end
        ARB_DONE: begin
          last_owner <= owner;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requesters and memory are driven
// from a transaction-level model that also predicts every output per cycle.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_wdata = '0;
  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  mem_port_arbiter_if #(.XLEN(32), .ADDR_SIZE(32)) bus_rr ();
  mem_port_arbiter_if #(.XLEN(32), .ADDR_SIZE(32)) bus_fx ();

  mem_port_arbiter #(.XLEN(32), .ADDR_SIZE(32), .FAIR(1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus_rr.slave));
  mem_port_arbiter #(.XLEN(32), .ADDR_SIZE(32), .FAIR(0), .TIMEOUT(TO)) dut_fixed (
    .clk(clk), .reset(reset), .bus(bus_fx.slave));

  assign bus_rr.i_req = i_req;       assign bus_fx.i_req = i_req;
  assign bus_rr.i_addr = i_addr;     assign bus_fx.i_addr = i_addr;
  assign bus_rr.d_req = d_req;       assign bus_fx.d_req = d_req;
  assign bus_rr.d_we = d_we;         assign bus_fx.d_we = d_we;
  assign bus_rr.d_addr = d_addr;     assign bus_fx.d_addr = d_addr;
  assign bus_rr.d_be = d_be;         assign bus_fx.d_be = d_be;
  assign bus_rr.d_wdata = d_wdata;   assign bus_fx.d_wdata = d_wdata;
  assign bus_rr.m_gnt = m_gnt;       assign bus_fx.m_gnt = m_gnt;
  assign bus_rr.m_rvalid = m_rvalid; assign bus_fx.m_rvalid = m_rvalid;
  assign bus_rr.m_rdata = m_rdata;   assign bus_fx.m_rdata = m_rdata;

  typedef struct packed {
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
  } obs_t;

  obs_t obs_rr, obs_fx, o;
  bit   sel = 1'b0;
  assign obs_rr = {bus_rr.i_ack, bus_rr.i_rdata, bus_rr.i_err, bus_rr.d_ack, bus_rr.d_rdata,
                   bus_rr.d_err, bus_rr.m_req, bus_rr.m_we, bus_rr.m_addr, bus_rr.m_be,
                   bus_rr.m_wdata};
  assign obs_fx = {bus_fx.i_ack, bus_fx.i_rdata, bus_fx.i_err, bus_fx.d_ack, bus_fx.d_rdata,
                   bus_fx.d_err, bus_fx.m_req, bus_fx.m_we, bus_fx.m_addr, bus_fx.m_be,
                   bus_fx.m_wdata};
  assign o = sel ? obs_fx : obs_rr;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model state
  bit          fair = 1'b1;
  bit          pend_i, pend_d, last_d;
  bit          out_v, out_d, out_we, granted;
  logic [31:0] out_addr, out_wd, resp_data;
  logic [3:0]  out_be;
  int          req_start, gnt_cyc, resp_cyc, ack_cyc, free_cyc;
  logic [31:0] exp_irdata = '0, exp_drdata = '0;
  logic [31:0] next_pc = 32'h8000_0000;
  logic [3:0]  be_tab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

  // Stimulus knobs (percentages unless noted)
  int p_i, p_d, gnt_pct, gnt_force, resp_max, to_pct, noise_pct, drop_pct;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d fair=%0d)", tag, got, exp, cyc, fair);
  endtask

  task automatic set_knobs(input int a, input int b, input int c, input int d,
                           input int e, input int f, input int g, input int h);
    p_i = a; p_d = b; gnt_pct = c; gnt_force = d;
    resp_max = e; to_pct = f; noise_pct = g; drop_pct = h;
  endtask

  task automatic model_clear();
    pend_i = 0; pend_d = 0; last_d = 0; out_v = 0; granted = 0;
    exp_irdata = '0; exp_drdata = '0; free_cyc = 0;
  endtask

  task automatic step();
    bit          exp_mreq, is_ack, to_ack, in_wait;
    int          k;
    logic [31:0] r;
    @(negedge clk);
    cyc++;

    // Bus request phase
    exp_mreq = out_v && (cyc >= req_start) && !(granted && cyc > gnt_cyc);
    chk("m_req", 64'(o.m_req), 64'(exp_mreq));
    if (exp_mreq) begin
      chk("m_we", 64'(o.m_we), 64'(out_we));
      chk("m_addr", 64'(o.m_addr), 64'(out_addr));
      chk("m_be", 64'(o.m_be), 64'(out_be));
      chk("m_wdata", 64'(o.m_wdata), 64'(out_wd));
    end

    // Completion
    is_ack = out_v && granted && (cyc == ack_cyc);
    to_ack = is_ack && (resp_cyc < 0);
    if (is_ack) begin
      if (out_d) begin exp_drdata = to_ack ? '0 : resp_data; exp_irdata = '0; end
      else       begin exp_irdata = to_ack ? '0 : resp_data; exp_drdata = '0; end
    end
    chk("i_ack", 64'(o.i_ack), 64'(is_ack && !out_d));
    chk("d_ack", 64'(o.d_ack), 64'(is_ack && out_d));
    chk("i_err", 64'(o.i_err), 64'(to_ack && !out_d));
    chk("d_err", 64'(o.d_err), 64'(to_ack && out_d));
    chk("i_rdata", 64'(o.i_rdata), 64'(exp_irdata));
    chk("d_rdata", 64'(o.d_rdata), 64'(exp_drdata));
    if (is_ack) begin
      if (out_d) begin pend_d = 0; d_req = 0; end
      else       begin pend_i = 0; i_req = 0; end
      last_d = out_d; out_v = 0; free_cyc = cyc + 1;
    end

    // Memory responder
    m_gnt = 0; m_rvalid = 0; m_rdata = $urandom;
    if (exp_mreq) begin
      if (($urandom_range(0, 99) < gnt_pct) || (cyc - req_start >= gnt_force)) begin
        m_gnt = 1; granted = 1; gnt_cyc = cyc;
        if ($urandom_range(0, 99) < to_pct) begin
          resp_cyc = -1; ack_cyc = cyc + 1 + TO;
        end else begin
          k = $urandom_range(1, resp_max);
          resp_cyc = cyc + k; ack_cyc = resp_cyc + 1; resp_data = $urandom;
        end
      end
    end else if ($urandom_range(0, 99) < noise_pct) m_gnt = 1;
    in_wait = out_v && granted && (cyc > gnt_cyc) && (cyc < ack_cyc);
    if (in_wait) begin
      if (cyc == resp_cyc) begin m_rvalid = 1; m_rdata = resp_data; end
    end else if ($urandom_range(0, 99) < noise_pct) m_rvalid = 1;

    // Owner may let go of its request once the arbiter holds the transaction
    if (out_v && cyc >= req_start && $urandom_range(0, 99) < drop_pct) begin
      if (out_d) d_req = 0; else i_req = 0;
    end

    // Requesters
    if (!pend_i && $urandom_range(0, 99) < p_i) begin
      pend_i = 1; i_req = 1; i_addr = next_pc; next_pc += 4;
    end
    if (!pend_d && $urandom_range(0, 99) < p_d) begin
      pend_d = 1; d_req = 1; d_we = 1'($urandom_range(0, 1));
      r = $urandom; d_addr = 32'h8000_1000 | (r & 32'h0000_0FFF);
      if (d_we) begin d_be = be_tab[$urandom_range(0, 6)]; d_wdata = $urandom; end
      else      begin d_be = 4'hF; d_wdata = '0; end
    end

    // Arbitration when the port is free
    if (!out_v && cyc >= free_cyc && (pend_i || pend_d)) begin
      out_d = pend_d && (!pend_i || !fair || !last_d);
      out_v = 1; granted = 0; req_start = cyc + 1;
      if (out_d) begin out_we = d_we; out_addr = d_addr; out_be = d_be; out_wd = d_wdata; end
      else       begin out_we = 0; out_addr = i_addr; out_be = 4'hF; out_wd = '0; end
    end
  endtask

  task automatic do_reset(input bit check_async);
    @(negedge clk);
    cyc++;
    reset = 1;
    #1;
    if (check_async) begin
      chk("rst_m_req", 64'(o.m_req), 64'd0);
      chk("rst_flags", 64'({o.i_ack, o.d_ack, o.i_err, o.d_err}), 64'd0);
      chk("rst_bus", 64'(|{o.m_we, o.m_addr, o.m_be, o.m_wdata}), 64'd0);
      chk("rst_rdata", 64'(|{o.i_rdata, o.d_rdata}), 64'd0);
    end
    i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
    @(negedge clk);
    cyc++;
    reset = 0;
    model_clear();
  endtask

  initial begin
    model_clear();
    do_reset(1'b0);

    // Lone fetches, zero-wait memory: back-to-back every 4 cycles
    set_knobs(100, 0, 100, 0, 1, 0, 0, 0);
    repeat (12) step();
    // Loads/stores with grant delayed 3 cycles
    set_knobs(0, 100, 0, 3, 2, 0, 0, 0);
    repeat (24) step();
    // Continuous conflict, round-robin
    set_knobs(100, 100, 100, 0, 1, 0, 0, 0);
    repeat (30) step();
    // Memory never answers; stray grants/responses around it
    set_knobs(0, 100, 100, 0, 1, 100, 30, 0);
    repeat (30) step();
    // Random mix
    for (int blk = 0; blk < 30; blk++) begin
      set_knobs($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(20, 100),
                $urandom_range(0, 6), $urandom_range(1, TO), $urandom_range(0, 20),
                $urandom_range(0, 40), $urandom_range(0, 30));
      repeat (100) step();
    end

    // Reset while waiting for memory, then stray responses, then normal service
    set_knobs(0, 100, 100, 0, 1, 100, 0, 0);
    for (int n = 0; n < 50 && !(out_v && granted && cyc > gnt_cyc); n++) step();
    chk("reach_wait", 64'(out_v && granted && cyc > gnt_cyc), 64'd1);
    do_reset(1'b1);
    set_knobs(0, 0, 0, 0, 1, 0, 100, 0);
    repeat (5) step();
    set_knobs(100, 0, 100, 0, 1, 0, 0, 0);
    repeat (10) step();

    // Fixed D-over-I priority instance
    sel = 1'b1;
    fair = 1'b0;
    do_reset(1'b0);
    set_knobs(100, 100, 100, 0, 1, 0, 0, 0);
    repeat (30) step();
    for (int blk = 0; blk < 10; blk++) begin
      set_knobs($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(20, 100),
                $urandom_range(0, 6), $urandom_range(1, TO), $urandom_range(0, 20),
                $urandom_range(0, 40), $urandom_range(0, 30));
      repeat (100) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
